// File: rtl/prio_enc_disp.sv
// Registered N-input priority encoder with GS/EO cascade flags, hold mode and a multiplexed
// active-low hex 7-segment driver. Define PENC_CHANGE_PULSE_EN to add the chg output.
module prio_enc_disp #(
   parameter int unsigned N_IN     = 16,
   parameter int unsigned DIGITS   = 2,
   parameter int unsigned SCAN_DIV = 1000,
   localparam int unsigned W       = $clog2(N_IN)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_IN-1:0]   I,
   input  logic              en,
   input  logic              hold,
   output logic [W-1:0]      Y,
   output logic              GS,
   output logic              EO,
   output logic [6:0]        HEX,
   output logic [DIGITS-1:0] DIG
`ifdef PENC_CHANGE_PULSE_EN
   ,
   output logic              chg
`endif
);

   localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned XW = 4 * DIGITS;

   logic [N_IN-1:0]   i_q;
   logic              en_q, hold_q;
   logic [W-1:0]      y_q, y_d;
   logic              gs_q, gs_d, eo_q, eo_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DW-1:0]     dig_idx_q, dig_idx_d;
   logic [6:0]        hex_q, hex_d;
   logic [DIGITS-1:0] dig_q, dig_d;
   logic [XW-1:0]     y_ext;
   logic [3:0]        nib;

   function automatic logic [6:0] font(input logic [3:0] v);
      case (v)
         4'h0: font = 7'b100_0000;
         4'h1: font = 7'b111_1001;
         4'h2: font = 7'b010_0100;
         4'h3: font = 7'b011_0000;
         4'h4: font = 7'b001_1001;
         4'h5: font = 7'b001_0010;
         4'h6: font = 7'b000_0010;
         4'h7: font = 7'b111_1000;
         4'h8: font = 7'b000_0000;
         4'h9: font = 7'b001_0000;
         4'hA: font = 7'b000_1000;
         4'hB: font = 7'b000_0011;
         4'hC: font = 7'b100_0110;
         4'hD: font = 7'b010_0001;
         4'hE: font = 7'b000_0110;
         default: font = 7'b000_1110;
      endcase
   endfunction

   // Ascending scan: the last set bit seen is the highest-priority one.
   always_comb begin
      y_d  = y_q;
      gs_d = gs_q;
      eo_d = eo_q;
      if (!hold_q) begin
         y_d  = '0;
         gs_d = 1'b0;
         eo_d = 1'b0;
         if (en_q) begin
            if (i_q == '0) begin
               eo_d = 1'b1;
            end else begin
               gs_d = 1'b1;
               for (int unsigned k = 0; k < N_IN; k++) begin
                  if (i_q[k]) y_d = k[W-1:0];
               end
            end
         end
      end
   end

   always_comb begin
      cnt_d     = cnt_q + 1'b1;
      dig_idx_d = dig_idx_q;
      if (cnt_q == CW'(SCAN_DIV - 1)) begin
         cnt_d     = '0;
         dig_idx_d = (dig_idx_q == DW'(DIGITS - 1)) ? '0 : dig_idx_q + 1'b1;
      end
   end

   assign y_ext = XW'(y_q);
   assign nib   = y_ext[dig_idx_q*4 +: 4];

   always_comb begin
      dig_d = ~(DIGITS'(1) << dig_idx_q);
      hex_d = gs_q ? font(nib) : 7'b011_1111;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         i_q       <= '0;
         en_q      <= 1'b0;
         hold_q    <= 1'b0;
         y_q       <= '0;
         gs_q      <= 1'b0;
         eo_q      <= 1'b0;
         cnt_q     <= '0;
         dig_idx_q <= '0;
         hex_q     <= 7'b111_1111;
         dig_q     <= '1;
      end else begin
         i_q       <= I;
         en_q      <= en;
         hold_q    <= hold;
         y_q       <= y_d;
         gs_q      <= gs_d;
         eo_q      <= eo_d;
         cnt_q     <= cnt_d;
         dig_idx_q <= dig_idx_d;
         hex_q     <= hex_d;
         dig_q     <= dig_d;
      end
   end

   assign Y   = y_q;
   assign GS  = gs_q;
   assign EO  = eo_q;
   assign HEX = hex_q;
   assign DIG = dig_q;

`ifdef PENC_CHANGE_PULSE_EN
   logic [W+1:0] prev_q;
   logic         chg_q;

   // prev_q resets to the reset value of {Y,GS,EO}, so nothing fires right after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_q <= '0;
         chg_q  <= 1'b0;
      end else begin
         prev_q <= {y_q, gs_q, eo_q};
         chg_q  <= ({y_q, gs_q, eo_q} != prev_q) && !hold_q;
      end
   end

   assign chg = chg_q;
`endif

endmodule

// File: tb/tb_prio_enc_disp.sv
// Self-checking bench for prio_enc_disp: directed plan steps, then random stimulus, all
// compared every cycle against a spec-level reference model.
module tb_prio_enc_disp;

   localparam int unsigned N_IN     = 16;
   localparam int unsigned DIGITS   = 2;
   localparam int unsigned SCAN_DIV = 4;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   logic [N_IN-1:0]   I     = '0;
   logic              en    = 1'b0;
   logic              hold  = 1'b0;
   logic [3:0]        Y;
   logic              GS, EO;
   logic [6:0]        HEX;
   logic [DIGITS-1:0] DIG;
`ifdef PENC_CHANGE_PULSE_EN
   logic              chg;
`endif

   int checks   = 0;
   int failures = 0;

   prio_enc_disp #(
      .N_IN    (N_IN),
      .DIGITS  (DIGITS),
      .SCAN_DIV(SCAN_DIV)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .I    (I),
      .en   (en),
      .hold (hold),
      .Y    (Y),
      .GS   (GS),
      .EO   (EO),
      .HEX  (HEX),
`ifdef PENC_CHANGE_PULSE_EN
      .DIG  (DIG),
      .chg  (chg)
`else
      .DIG  (DIG)
`endif
   );

   always #5 clk = ~clk;

   logic [6:0] font [16] = '{7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000,
                             7'b001_1001, 7'b001_0010, 7'b000_0010, 7'b111_1000,
                             7'b000_0000, 7'b001_0000, 7'b000_1000, 7'b000_0011,
                             7'b100_0110, 7'b010_0001, 7'b000_0110, 7'b000_1110};

   // Reference state: what was sampled last edge, the encoder outputs, the display outputs.
   int         s_i, s_en, s_hold;
   int         m_y, m_gs, m_eo;
   int         m_hex, m_dig, m_chg, m_prev;
   int         ncyc;

   task automatic model_edge(input int i, input int e, input int h, input int r);
      int ny, ngs, neo, d;
      if (!r) begin
         s_i = 0; s_en = 0; s_hold = 0;
         m_y = 0; m_gs = 0; m_eo = 0;
         m_hex = 7'h7F; m_dig = (1 << DIGITS) - 1;
         m_chg = 0; m_prev = 0; ncyc = 0;
      end else begin
         if (s_hold != 0) begin
            ny = m_y; ngs = m_gs; neo = m_eo;
         end else if (s_en == 0) begin
            ny = 0; ngs = 0; neo = 0;
         end else if (s_i == 0) begin
            ny = 0; ngs = 0; neo = 1;
         end else begin
            ny = $clog2(s_i + 1) - 1; ngs = 1; neo = 0;
         end
         d     = (ncyc / SCAN_DIV) % DIGITS;
         m_dig = ((1 << DIGITS) - 1) & ~(1 << d);
         m_hex = (m_gs != 0) ? int'(font[(m_y >> (4 * d)) & 15]) : 7'h3F;
         m_chg = ((m_y * 4 + m_gs * 2 + m_eo) != m_prev && s_hold == 0) ? 1 : 0;
         m_prev = m_y * 4 + m_gs * 2 + m_eo;
         m_y = ny; m_gs = ngs; m_eo = neo;
         ncyc++;
         s_i = i; s_en = e; s_hold = h;
      end
   endtask

   task automatic check_all();
      checks++;
      assert (Y === 4'(m_y)) else begin
         failures++; $error("FAIL Y got=%0h exp=%0h", Y, m_y);
      end
      checks++;
      assert (GS === 1'(m_gs)) else begin
         failures++; $error("FAIL GS got=%0b exp=%0b", GS, m_gs);
      end
      checks++;
      assert (EO === 1'(m_eo)) else begin
         failures++; $error("FAIL EO got=%0b exp=%0b", EO, m_eo);
      end
      checks++;
      assert (HEX === 7'(m_hex)) else begin
         failures++; $error("FAIL HEX got=%07b exp=%07b", HEX, 7'(m_hex));
      end
      checks++;
      assert (DIG === DIGITS'(m_dig)) else begin
         failures++; $error("FAIL DIG got=%b exp=%b", DIG, DIGITS'(m_dig));
      end
`ifdef PENC_CHANGE_PULSE_EN
      checks++;
      assert (chg === 1'(m_chg)) else begin
         failures++; $error("FAIL chg got=%0b exp=%0b", chg, m_chg);
      end
`endif
   endtask

   task automatic step(input logic [15:0] i, input logic e, input logic h, input logic r);
      @(negedge clk);
      I = i; en = e; hold = h; rst_n = r;
      @(posedge clk);
      model_edge(int'(i), int'(e), int'(h), int'(r));
      #1;
      check_all();
   endtask

   task automatic steps(input int n, input logic [15:0] i, input logic e, input logic h);
      for (int k = 0; k < n; k++) step(i, e, h, 1'b1);
   endtask

   initial begin
      logic [15:0] ri;
      logic        re, rh, rr;
      steps(0, 16'h0, 1'b0, 1'b0);
      step(16'h0, 1'b0, 1'b0, 1'b0);
      step(16'h0, 1'b0, 1'b0, 1'b0);
      // All-zero request with enable: EO then dashes on both digits.
      steps(10, 16'h0000, 1'b1, 1'b0);
      // Highest bit wins: F on digit 0, 0 on digit 1.
      steps(10, 16'h8421, 1'b1, 1'b0);
      // Hold freezes Y=5 while I changes; release picks up 8.
      steps(4, 16'h0030, 1'b1, 1'b0);
      steps(6, 16'h0100, 1'b1, 1'b1);
      steps(4, 16'h0100, 1'b1, 1'b0);
      // Disabled: no outputs asserted despite all requests.
      steps(6, 16'hFFFF, 1'b0, 1'b0);
      // Reset mid-scan restarts the digit counter.
      steps(5, 16'h0ABC, 1'b1, 1'b0);
      step(16'h0ABC, 1'b1, 1'b0, 1'b0);
      steps(10, 16'h0ABC, 1'b1, 1'b0);
      // Change pulse: 1 -> 2 pulses, 2 -> 3 keeps Y=1 so no pulse.
      steps(4, 16'h0001, 1'b1, 1'b0);
      steps(4, 16'h0002, 1'b1, 1'b0);
      steps(4, 16'h0003, 1'b1, 1'b0);
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 3))
            0:       ri = 16'h0;
            1:       ri = 16'h1 << $urandom_range(0, 15);
            default: ri = 16'($urandom);
         endcase
         re = ($urandom_range(0, 7) != 0);
         rh = ($urandom_range(0, 3) == 0);
         rr = ($urandom_range(0, 49) != 0);
         step(ri, re, rh, rr);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
